// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ram_arbiter
//  Description : Shares one RAM read port and one write port between the
//                instruction-fetch (IF) and load/store (MEM) requesters.
//                MEM has fixed priority; IF is forced through after being
//                denied STARVE_LIMIT consecutive cycles. Responses are
//                registered and presented one cycle after the grant.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  // instruction fetch requester
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ready_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  // load/store requester
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic              mem_ready_o,
  output logic              mem_rvalid_o,
  output logic [DATA_W-1:0] mem_rdata_o,
  // RAM side
  output logic [ADDR_W-1:0] ram_raddr_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic [ADDR_W-1:0] ram_waddr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  output logic              ram_we_o
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_IF_RSP  = 2'd1,
    S_MEM_RSP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              if_gnt, mem_gnt;

  // Grant selection: starved IF first, then MEM, then IF; nothing during reset
  always_comb begin
    if_gnt  = 1'b0;
    mem_gnt = 1'b0;
    if (!rst) begin
      if (if_req_i && (starve_q == STARVE_MAX)) begin
        if_gnt = 1'b1;
      end else if (mem_req_i) begin
        mem_gnt = 1'b1;
      end else if (if_req_i) begin
        if_gnt = 1'b1;
      end
    end
  end

  // Count consecutive denied IF cycles, saturating at the limit
  always_comb begin
    starve_d = 4'd0;
    if (if_req_i && !if_gnt) begin
      starve_d = (starve_q >= STARVE_MAX) ? STARVE_MAX : starve_q + 4'd1;
    end
  end

  // Next response state follows whichever requester was granted this cycle
  always_comb begin
    state_d = S_IDLE;
    if (if_gnt) begin
      state_d = S_IF_RSP;
    end else if (mem_gnt) begin
      state_d = S_MEM_RSP;
    end
  end

  // Capture read data on grant; a MEM write acknowledges with zero data
  always_comb begin
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if (if_gnt) begin
      if_rdata_d = ram_rdata_i;
    end
    if (mem_gnt) begin
      mem_rdata_d = mem_we_i ? '0 : ram_rdata_i;
    end
  end

  // State, counter and response data registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      starve_q    <= 4'd0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign if_ready_o   = if_gnt;
  assign mem_ready_o  = mem_gnt;
  assign if_rvalid_o  = (state_q == S_IF_RSP);
  assign mem_rvalid_o = (state_q == S_MEM_RSP);
  assign if_rdata_o   = if_rdata_q;
  assign mem_rdata_o  = mem_rdata_q;

  // The read port follows IF only when IF wins; otherwise it tracks MEM
  assign ram_raddr_o = if_gnt ? if_addr_i : mem_addr_i;
  assign ram_waddr_o = mem_addr_i;
  assign ram_wdata_o = mem_wdata_i;
  assign ram_we_o    = mem_gnt & mem_we_i;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_ram_arbiter
//  Description : Self-checking bench for ram_arbiter with a RAM model, a
//                rule-level reference model and directed plus random stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, mem_req, mem_we;
  logic [63:0] if_addr, mem_addr, mem_wdata;
  logic        if_ready, if_rvalid, mem_ready, mem_rvalid, ram_we;
  logic [63:0] if_rdata, mem_rdata, ram_raddr, ram_rdata, ram_waddr, ram_wdata;

  logic [63:0] ram  [256];   // the RAM the arbiter drives
  logic [63:0] gold [256];   // the model's own view of memory contents

  int checks = 0;
  int errors = 0;

  ram_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_ready_o(if_ready),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_addr_i(mem_addr),
    .mem_wdata_i(mem_wdata), .mem_ready_o(mem_ready),
    .mem_rvalid_o(mem_rvalid), .mem_rdata_o(mem_rdata),
    .ram_raddr_o(ram_raddr), .ram_rdata_i(ram_rdata),
    .ram_waddr_o(ram_waddr), .ram_wdata_o(ram_wdata), .ram_we_o(ram_we)
  );

  always #5 clk = ~clk;

  // RAM: combinational read, write lands on the rising edge
  assign ram_rdata = ram[ram_raddr[7:0]];
  always @(posedge clk) if (ram_we) ram[ram_waddr[7:0]] <= ram_wdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          started = 0;
  int          denied  = 0;       // consecutive cycles IF asked and lost
  bit          exp_ifv = 0, exp_memv = 0;
  logic [63:0] exp_ifd = '0, exp_memd = '0;

  task automatic model_reset();
    denied = 0; exp_ifv = 0; exp_memv = 0; exp_ifd = '0; exp_memd = '0;
  endtask

  // Compare process: outputs settle 2ns after the negedge input change
  always @(negedge clk) begin
    bit e_if, e_mem;
    #2;
    if (!started) begin
      if (rst) begin started = 1; model_reset(); end
    end else begin
      e_if  = !rst && if_req && (denied >= LIM || !mem_req);
      e_mem = !rst && mem_req && !e_if;
      chk("if_ready",   {63'd0, if_ready},   {63'd0, e_if});
      chk("mem_ready",  {63'd0, mem_ready},  {63'd0, e_mem});
      chk("ram_we",     {63'd0, ram_we},     {63'd0, e_mem && mem_we});
      if (e_if) chk("raddr_if", ram_raddr, if_addr);
      else if (e_mem && !mem_we) chk("raddr_mem", ram_raddr, mem_addr);
      chk("ram_waddr",  ram_waddr, mem_addr);
      chk("ram_wdata",  ram_wdata, mem_wdata);
      chk("if_rvalid",  {63'd0, if_rvalid},  {63'd0, exp_ifv});
      chk("mem_rvalid", {63'd0, mem_rvalid}, {63'd0, exp_memv});
      chk("if_rdata",   if_rdata,  exp_ifd);
      chk("mem_rdata",  mem_rdata, exp_memd);
      if (rst) begin
        model_reset();
      end else begin
        denied  = (if_req && !e_if) ? denied + 1 : 0;
        exp_ifv = e_if;
        if (e_if) exp_ifd = gold[if_addr[7:0]];
        exp_memv = e_mem;
        if (e_mem) begin
          if (mem_we) begin exp_memd = '0; gold[mem_addr[7:0]] = mem_wdata; end
          else exp_memd = gold[mem_addr[7:0]];
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic r, input logic ir, input logic [63:0] ia,
                       input logic mr, input logic mw, input logic [63:0] ma,
                       input logic [63:0] md);
    @(negedge clk);
    rst = r; if_req = ir; if_addr = ia;
    mem_req = mr; mem_we = mw; mem_addr = ma; mem_wdata = md;
    #3;
  endtask

  task automatic idle();
    drive(0, 0, 64'h0, 0, 0, 64'h0, 64'h0);
  endtask

  initial begin
    logic [9:0] pat10;
    logic [8:0] pat9;
    bit         if_acc, mem_acc;

    for (int i = 0; i < 256; i++) begin
      ram[i]  = {$urandom, $urandom};
      gold[i] = ram[i];
    end
    ram[8'h10] = 64'hAA;   gold[8'h10] = 64'hAA;
    ram[8'h30] = 64'h5555; gold[8'h30] = 64'h5555;

    rst = 1; if_req = 0; mem_req = 0; mem_we = 0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0;
    repeat (3) @(negedge clk);
    idle();
    chk("lit_reset_if_rvalid", {63'd0, if_rvalid}, 64'd0);
    chk("lit_reset_if_rdata",  if_rdata,  64'd0);
    chk("lit_reset_mem_rdata", mem_rdata, 64'd0);

    // IF alone
    drive(0, 1, 64'h10, 0, 0, 64'h0, 64'h0);
    chk("lit_ifonly_ready", {63'd0, if_ready}, 64'd1);
    drive(0, 1, 64'h11, 0, 0, 64'h0, 64'h0);
    chk("lit_ifonly_rvalid", {63'd0, if_rvalid}, 64'd1);
    chk("lit_ifonly_rdata",  if_rdata, 64'hAA);
    drive(0, 1, 64'h12, 0, 0, 64'h0, 64'h0);
    idle();

    // Contention: four MEM grants, then forced IF, repeating
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 64'h5, 1, 0, 64'h6, 64'h0);
      pat10[i] = if_ready;
    end
    chk("lit_contention_pattern", {54'd0, pat10}, {54'd0, 10'b1000010000});
    idle();

    // Write then read of the same address
    drive(0, 0, 64'h0, 1, 1, 64'h20, 64'h1234);
    chk("lit_wr_ram_we", {63'd0, ram_we}, 64'd1);
    drive(0, 1, 64'h20, 0, 0, 64'h20, 64'h0);
    chk("lit_wr_ack_rvalid", {63'd0, mem_rvalid}, 64'd1);
    chk("lit_wr_ack_rdata",  mem_rdata, 64'd0);
    idle();
    chk("lit_rd_after_wr", if_rdata, 64'h1234);

    // Idle: nothing granted, data registers hold
    idle();
    chk("lit_idle_ready", {62'd0, if_ready, mem_ready}, 64'd0);
    chk("lit_idle_hold",  if_rdata, 64'h1234);

    // Reset in the same cycle as a MEM write, with an IF response pending
    drive(0, 1, 64'h40, 0, 0, 64'h0, 64'h0);
    drive(1, 0, 64'h0, 1, 1, 64'h30, 64'hDEAD);
    chk("lit_rst_ram_we", {63'd0, ram_we}, 64'd0);
    drive(0, 1, 64'h30, 0, 0, 64'h0, 64'h0);
    chk("lit_rst_rvalid", {62'd0, if_rvalid, mem_rvalid}, 64'd0);
    chk("lit_rst_resume", {63'd0, if_ready}, 64'd1);
    idle();
    chk("lit_rst_no_write", if_rdata, 64'h5555);

    // Starve counter clears when IF drops its request
    idle();
    for (int i = 0; i < 9; i++) begin
      drive(0, (i != 3), 64'h7, 1, 0, 64'h8, 64'h0);
      pat9[i] = if_ready;
    end
    chk("lit_starve_clear", {55'd0, pat9}, {55'd0, 9'b100000000});
    idle();

    // Random traffic; requests are held until accepted
    if_acc = 1; mem_acc = 1;
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 99) == 0);
      if (!(if_req && !if_acc)) begin
        if_req  = ($urandom_range(0, 2) != 0);
        if_addr = 64'($urandom_range(0, 31));
      end
      if (!(mem_req && !mem_acc)) begin
        mem_req   = ($urandom_range(0, 2) != 0);
        mem_we    = $urandom_range(0, 1) == 1;
        mem_addr  = 64'($urandom_range(0, 31));
        mem_wdata = {$urandom, $urandom};
      end
      #3;
      if_acc  = if_ready;
      mem_acc = mem_ready;
    end
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
